filt_frame_scheduler: RTL

FILT_FRAME_SCHEDULER -- requirements
Module: filt_frame_scheduler

---
 rtl/filt_frame_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/filt_frame_scheduler.sv
// filt_frame_scheduler
//
// Schedules two frame buffers between a producer (disparity engine), a
// post-filter engine and a consumer. Each buffer moves through
//   EMPTY -> WRITING -> PEND -> FILTERING -> FULL -> READING -> EMPTY
// or, with FILT_BYPASS=1, straight from WRITING to FULL.
// Frames are filtered and read in the order the producer finished them.
//
// Handshakes: a requester holds its req level high. The scheduler answers
// with a one-cycle grant, computed combinationally in the same cycle from
// registered buffer state, and the buffer index next to it. The index stays
// valid until the matching done pulse. A done pulse with no buffer in the
// matching state is dropped and raises the sticky proto_err flag.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_req/wr_grant/wr_buf/wr_done   producer side
//   filt_start/filt_buf/filt_idle    filter engine side
//   rd_req/rd_grant/rd_buf/rd_done   consumer side
//   frames_out            frames completed by the consumer (wraps)
//   proto_err             sticky protocol-error flag
//   filt_state            filter FSM state, for debug/checkers
module filt_frame_scheduler #(
  parameter int FILT_TAIL   = 8,
  parameter bit FILT_BYPASS = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  output logic             wr_grant,
  output logic             wr_buf,
  input  logic             wr_done,
  output logic             filt_start,
  output logic             filt_buf,
  input  logic             filt_idle,
  input  logic             rd_req,
  output logic             rd_grant,
  output logic             rd_buf,
  input  logic             rd_done,
  output logic [CNT_W-1:0] frames_out,
  output logic             proto_err,
  output logic [1:0]       filt_state
);

  localparam int TAIL_W = (FILT_TAIL > 0) ? $clog2(FILT_TAIL + 1) : 1;

  typedef enum logic [2:0] {
    B_EMPTY, B_WRITING, B_PEND, B_FILTERING, B_FULL, B_READING
  } buf_state_t;

  typedef enum logic [1:0] {
    F_IDLE, F_LAUNCH, F_RUN, F_TAIL
  } filt_state_t;

  buf_state_t  buf_st  [2];
  buf_state_t  buf_nxt [2];
  filt_state_t f_st, f_nxt;

  logic [1:0]        launch_cnt, launch_nxt;
  logic [TAIL_W-1:0] tail_cnt, tail_nxt;
  logic              newest;      // buffer whose wr_done came last
  logic              wr_buf_q, rd_buf_q, filt_buf_q;
  logic              launch_err;

  logic writing_any, writing_idx, reading_any, reading_idx;
  logic empty0, empty1, pend0, pend1, full0, full1;
  logic wr_pick, pend_pick, full_pick;
  logic wr_done_ok, rd_done_ok;

  assign writing_any = (buf_st[0] == B_WRITING) || (buf_st[1] == B_WRITING);
  assign writing_idx = (buf_st[1] == B_WRITING);
  assign reading_any = (buf_st[0] == B_READING) || (buf_st[1] == B_READING);
  assign reading_idx = (buf_st[1] == B_READING);
  assign empty0      = (buf_st[0] == B_EMPTY);
  assign empty1      = (buf_st[1] == B_EMPTY);
  assign pend0       = (buf_st[0] == B_PEND);
  assign pend1       = (buf_st[1] == B_PEND);
  assign full0       = (buf_st[0] == B_FULL);
  assign full1       = (buf_st[1] == B_FULL);

  // Lowest-index EMPTY buffer wins a write grant.
  assign wr_pick   = !empty0;
  // With two candidates the older one is the buffer that was not finished
  // last; with one candidate it is simply that one.
  assign pend_pick = (pend0 && pend1) ? ~newest : pend1;
  assign full_pick = (full0 && full1) ? ~newest : full1;

  assign wr_grant   = wr_req && !writing_any && (empty0 || empty1);
  assign rd_grant   = rd_req && !reading_any && (full0 || full1);
  assign wr_done_ok = wr_done && writing_any;
  assign rd_done_ok = rd_done && reading_any;

  assign wr_buf     = wr_grant   ? wr_pick   : wr_buf_q;
  assign rd_buf     = rd_grant   ? full_pick : rd_buf_q;
  assign filt_buf   = filt_start ? pend_pick : filt_buf_q;
  assign filt_state = f_st;

  // Next-state for both buffers and the filter FSM. Every event targets a
  // buffer in a distinct state, so all same-cycle events land on different
  // buffers and can be applied independently.
  always_comb begin
    buf_nxt[0] = buf_st[0];
    buf_nxt[1] = buf_st[1];
    f_nxt      = f_st;
    launch_nxt = launch_cnt;
    tail_nxt   = tail_cnt;
    filt_start = 1'b0;
    launch_err = 1'b0;

    if (wr_grant)   buf_nxt[wr_pick]     = B_WRITING;
    if (wr_done_ok) buf_nxt[writing_idx] = FILT_BYPASS ? B_FULL : B_PEND;
    if (rd_grant)   buf_nxt[full_pick]   = B_READING;
    if (rd_done_ok) buf_nxt[reading_idx] = B_EMPTY;

    case (f_st)
      F_IDLE: begin
        if (filt_idle && (pend0 || pend1)) begin
          filt_start         = 1'b1;
          buf_nxt[pend_pick] = B_FILTERING;
          launch_nxt         = 2'd0;
          f_nxt              = F_LAUNCH;
        end
      end
      F_LAUNCH: begin
        // The filter must drop idle within four cycles of the start pulse;
        // otherwise the frame is handed back to PEND for another attempt.
        if (!filt_idle) begin
          f_nxt = F_RUN;
        end else if (launch_cnt == 2'd3) begin
          launch_err          = 1'b1;
          buf_nxt[filt_buf_q] = B_PEND;
          f_nxt               = F_IDLE;
        end else begin
          launch_nxt = launch_cnt + 2'd1;
        end
      end
      F_RUN: begin
        if (filt_idle) begin
          tail_nxt = TAIL_W'(FILT_TAIL);
          f_nxt    = F_TAIL;
        end
      end
      F_TAIL: begin
        // Write-back drain: FILT_TAIL+1 cycles here in total.
        if (tail_cnt == '0) begin
          buf_nxt[filt_buf_q] = B_FULL;
          f_nxt               = F_IDLE;
        end else begin
          tail_nxt = tail_cnt - TAIL_W'(1);
        end
      end
      default: f_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_st[0]  <= B_EMPTY;
      buf_st[1]  <= B_EMPTY;
      f_st       <= F_IDLE;
      launch_cnt <= '0;
      tail_cnt   <= '0;
      newest     <= 1'b0;
      wr_buf_q   <= 1'b0;
      rd_buf_q   <= 1'b0;
      filt_buf_q <= 1'b0;
      frames_out <= '0;
      proto_err  <= 1'b0;
    end else begin
      buf_st[0]  <= buf_nxt[0];
      buf_st[1]  <= buf_nxt[1];
      f_st       <= f_nxt;
      launch_cnt <= launch_nxt;
      tail_cnt   <= tail_nxt;
      if (wr_done_ok) newest     <= writing_idx;
      if (wr_grant)   wr_buf_q   <= wr_pick;
      if (rd_grant)   rd_buf_q   <= full_pick;
      if (filt_start) filt_buf_q <= pend_pick;
      if (rd_done_ok) frames_out <= frames_out + CNT_W'(1);
      if (launch_err || (wr_done && !writing_any) || (rd_done && !reading_any))
        proto_err <= 1'b1;
    end
  end

endmodule
